tmds_timing_gen: RTL and testbench
==================================

Name: tmds_timing_gen

Overview:
- Parametrised successor to tmds_timing. Recovers horizontal/vertical raster counters from the received TMDS hsync/vsync in the rx0_pclk domain.
- Generates video_en for a programmable active window.
- Measures htotal/vtotal and runs a lock state machine; video_en is gated until the incoming timing has been stable for LOCK_FRAMES frames.
- Sits between the DVI/TMDS decoder and the packetiser/framebuffer logic.

Parameters:
- HCNT_W, 12, width of horizontal counter and htotal.
- VCNT_W, 11, width of vertical counter and vtotal.
- HS_POL, 1, hsync active level (1 = active-high, 0 = active-low).
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low).
- H_START, 220, hcnt value of the first active pixel.
- H_ACTIVE, 1280, active pixels per line.
- V_START, 20, vcnt value of the first active line.
- V_ACTIVE, 720, active lines per frame.
- LOCK_FRAMES, 2, consecutive matching frames required to enter LOCKED (1..15).

Ports:
- rx0_pclk  in  1  pixel clock; all logic on its rising edge.
- rstbtn_n  in  1  reset, asynchronous, active-high (the name is historical; the polarity is high).
- rx0_hsync  in  1  received hsync, synchronous to rx0_pclk.
- rx0_vsync  in  1  received vsync, synchronous to rx0_pclk.
- video_en  out  1  high for active pixels while locked.
- video_hcnt  out  HCNT_W  horizontal counter; 0 at the hsync leading edge.
- video_vcnt  out  VCNT_W  vertical counter; 0 at the vsync leading edge.
- htotal  out  HCNT_W  last measured line length, in clocks.
- vtotal  out  VCNT_W  last measured frame length, in lines.
- locked  out  1  timing stable.
- frame_start  out  1  one-cycle pulse at each vsync leading edge.

Behaviour:
- Reset: all outputs 0, FSM in UNLOCK, internal match counter 0, sync history registers hold the inactive level.
- Sync normalisation and edge detect:
  - hs = rx0_hsync XNOR HS_POL; vs = rx0_vsync XNOR VS_POL.
  - Each is registered twice (s1, s2).
  - A leading edge is s1=1 & s2=0, i.e. detected 2 clocks after the input first goes active.
- Horizontal counter:
  - On an hs edge: htotal <= video_hcnt+1 and video_hcnt <= 0.
  - Otherwise video_hcnt increments, saturating at 2^HCNT_W-1 (no wrap).
- Vertical counter:
  - On a vs edge: vtotal <= video_vcnt, video_vcnt <= 0, frame_start=1 for one cycle.
  - Else, on an hs edge, video_vcnt increments, saturating at 2^VCNT_W-1.
  - Simultaneous hs and vs edge: the vs rule wins for vcnt; the hs rule still applies to hcnt/htotal.
- Line check: on each hs edge, compare the new line length with a reference line length; any difference sets a frame-error flag. The reference is reloaded at each vs edge from the first line of the frame.
- Lock FSM, evaluated at each vs edge (registered):
  - UNLOCK -> TRACK unconditionally; match count cleared.
  - TRACK: if no frame error and vtotal unchanged from the previous frame, match count +1. On reaching LOCK_FRAMES -> LOCKED, locked=1. Any mismatch clears the match count and stays in TRACK.
  - LOCKED: a frame error, a vtotal change, or a line-length mismatch on any hs edge (checked immediately, not only at vs) -> UNLOCK, locked=0 on the next cycle.
  - Any state: saturation of hcnt or vcnt (sync loss) -> UNLOCK.
- video_en (registered, 1 cycle after the counters) = locked & H_START <= hcnt < H_START+H_ACTIVE & V_START <= vcnt < V_START+V_ACTIVE. It drops 1 cycle after locked falls.
- Comparisons are unsigned at full parameter width. H_START+H_ACTIVE must fit in HCNT_W and V_START+V_ACTIVE must fit in VCNT_W; this is checked by elaboration-time assertion.
- Reset mid-frame: immediate return to reset values. Relock requires a full vs edge plus LOCK_FRAMES frames.

Test Plan:
- Reset: assert rstbtn_n for 3 clocks mid-stream -> all outputs 0 asynchronously; locked stays 0 until 1+LOCK_FRAMES vs edges after release.
- Nominal lock: HS_POL=VS_POL=1, htotal 100 clocks (hsync 10 high), 20 lines/frame, H_START=20, H_ACTIVE=64, V_START=3, V_ACTIVE=15, LOCK_FRAMES=2 -> htotal=100, vtotal=20, locked=1 after the 3rd vs edge. video_en then gives exactly 64×15 = 960 cycles per frame, first at hcnt=20, vcnt=3.
- Polarity: same stimulus inverted with HS_POL=VS_POL=0 -> identical counters, lock timing and video_en.
- Line glitch: while locked, one line shortened to 98 clocks -> htotal=98, locked=0 and video_en=0 within 1 cycle after that hs edge; relock 3 frames later.
- Sync loss: hsync held inactive for 2^HCNT_W clocks -> video_hcnt saturates at 4095, locked=0, no counter wrap.
- Simultaneous edges: hsync and vsync leading edges in the same clock -> video_hcnt=0, video_vcnt=0 (not 1), frame_start pulses once, vtotal latched correctly.

Source files
------------

// File: rtl/tmds_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tmds_timing_gen
// Purpose  : Recovers raster counters from received TMDS hsync/vsync, measures
//            htotal/vtotal and gates video_en behind a frame-lock state machine.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_timing_gen #(
    parameter int HCNT_W      = 12,
    parameter int VCNT_W      = 11,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int H_START     = 220,
    parameter int H_ACTIVE    = 1280,
    parameter int V_START     = 20,
    parameter int V_ACTIVE    = 720,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              rx0_pclk,
    input  logic              rstbtn_n,
    input  logic              rx0_hsync,
    input  logic              rx0_vsync,
    output logic              video_en,
    output logic [HCNT_W-1:0] video_hcnt,
    output logic [VCNT_W-1:0] video_vcnt,
    output logic [HCNT_W-1:0] htotal,
    output logic [VCNT_W-1:0] vtotal,
    output logic              locked,
    output logic              frame_start
);

    localparam logic [HCNT_W-1:0] H_ONE = HCNT_W'(1);
    localparam logic [VCNT_W-1:0] V_ONE = VCNT_W'(1);
    localparam logic [HCNT_W-1:0] H_LO  = HCNT_W'(H_START);
    localparam logic [HCNT_W-1:0] H_HI  = HCNT_W'(H_START + H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LO  = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] V_HI  = VCNT_W'(V_START + V_ACTIVE);
    localparam logic [3:0]        LF    = 4'(LOCK_FRAMES);

    generate
        if (H_START + H_ACTIVE > (1 << HCNT_W) - 1) begin : g_hwin_err
            $error("H_START + H_ACTIVE does not fit in HCNT_W");
        end
        if (V_START + V_ACTIVE > (1 << VCNT_W) - 1) begin : g_vwin_err
            $error("V_START + V_ACTIVE does not fit in VCNT_W");
        end
        if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_lock_err
            $error("LOCK_FRAMES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d, htotal_q, htotal_d, ref_q, ref_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d, vtotal_q, vtotal_d;
    logic                ref_vld_q, ref_vld_d, ferr_q, ferr_d, first_q, first_d;
    logic [3:0]          match_q, match_d, match_inc;
    logic                fs_q, fs_d, locked_q, locked_d, en_q, en_d;
    logic                hs_n, vs_n, hs_edge, vs_edge, hsat, vsat;
    logic                line_mis, vt_same, in_win;
    logic [HCNT_W-1:0]   line_len;

    assign hs_n      = ~(rx0_hsync ^ HS_POL);
    assign vs_n      = ~(rx0_vsync ^ VS_POL);
    assign hs_edge   = hs_s1_q & ~hs_s2_q;
    assign vs_edge   = vs_s1_q & ~vs_s2_q;
    assign hsat      = &hcnt_q;
    assign vsat      = &vcnt_q;
    assign line_len  = hcnt_q + H_ONE;
    assign match_inc = match_q + 4'd1;
    assign vt_same   = (vcnt_q == vtotal_q);
    // A vs edge restarts the reference, so a coincident hs edge is not checked.
    assign line_mis  = hs_edge & ~vs_edge & ref_vld_q & (line_len != ref_q);
    assign in_win    = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                       (vcnt_q >= V_LO) && (vcnt_q < V_HI);

    always_comb begin
        hcnt_d    = hcnt_q;
        htotal_d  = htotal_q;
        vcnt_d    = vcnt_q;
        vtotal_d  = vtotal_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        ferr_d    = ferr_q;
        first_d   = first_q;
        match_d   = match_q;
        state_d   = state_q;
        fs_d      = 1'b0;

        if (hs_edge) begin
            hcnt_d   = '0;
            htotal_d = line_len;
        end else if (!hsat) begin
            hcnt_d = hcnt_q + H_ONE;
        end

        if (vs_edge) begin
            vtotal_d  = vcnt_q;
            vcnt_d    = '0;
            fs_d      = 1'b1;
            ref_vld_d = 1'b0;
            ferr_d    = 1'b0;
        end else if (hs_edge) begin
            if (!vsat) begin
                vcnt_d = vcnt_q + V_ONE;
            end
            if (!ref_vld_q) begin
                ref_d     = line_len;
                ref_vld_d = 1'b1;
            end else if (line_len != ref_q) begin
                ferr_d = 1'b1;
            end
        end

        case (state_q)
            ST_UNLOCK: begin
                if (vs_edge) begin
                    state_d = ST_TRACK;
                    match_d = '0;
                    first_d = 1'b1;
                end
            end
            ST_TRACK: begin
                // The frame closed by the first tracked vs edge has no
                // full-frame vtotal to compare against, so only lines count.
                if (vs_edge) begin
                    first_d = 1'b0;
                    if (!ferr_q && (first_q || vt_same)) begin
                        match_d = match_inc;
                        if (match_inc == LF) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_mis || (vs_edge && (ferr_q || !vt_same))) begin
                    state_d = ST_UNLOCK;
                end
            end
            default: state_d = ST_UNLOCK;
        endcase

        if (hsat || vsat) begin
            state_d = ST_UNLOCK;
            match_d = '0;
        end
    end

    assign locked_d = (state_d == ST_LOCKED);
    assign en_d     = locked_q & in_win;

    always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            hs_s1_q   <= 1'b0;
            hs_s2_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            hcnt_q    <= '0;
            htotal_q  <= '0;
            vcnt_q    <= '0;
            vtotal_q  <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            ferr_q    <= 1'b0;
            first_q   <= 1'b0;
            match_q   <= '0;
            state_q   <= ST_UNLOCK;
            fs_q      <= 1'b0;
            locked_q  <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            hs_s1_q   <= hs_n;
            hs_s2_q   <= hs_s1_q;
            vs_s1_q   <= vs_n;
            vs_s2_q   <= vs_s1_q;
            hcnt_q    <= hcnt_d;
            htotal_q  <= htotal_d;
            vcnt_q    <= vcnt_d;
            vtotal_q  <= vtotal_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            ferr_q    <= ferr_d;
            first_q   <= first_d;
            match_q   <= match_d;
            state_q   <= state_d;
            fs_q      <= fs_d;
            locked_q  <= locked_d;
            en_q      <= en_d;
        end
    end

    assign video_en    = en_q;
    assign video_hcnt  = hcnt_q;
    assign video_vcnt  = vcnt_q;
    assign htotal      = htotal_q;
    assign vtotal      = vtotal_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_timing_gen
// Purpose  : Directed self-checking bench; a 100x20 raster drives an
//            active-high instance and an inverted-polarity instance together.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_timing_gen;

    localparam int HW = 12;
    localparam int VW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b1, vs_b = 1'b1;
    logic          en_a, en_b, lk_a, lk_b, fs_a, fs_b;
    logic [HW-1:0] hc_a, hc_b, ht_a, ht_b;
    logic [VW-1:0] vc_a, vc_b, vt_a, vt_b;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    tmds_timing_gen #(
        .HCNT_W(HW), .VCNT_W(VW), .HS_POL(1'b1), .VS_POL(1'b1),
        .H_START(20), .H_ACTIVE(64), .V_START(3), .V_ACTIVE(15), .LOCK_FRAMES(2)
    ) dut_a (
        .rx0_pclk(clk), .rstbtn_n(rst), .rx0_hsync(hs_a), .rx0_vsync(vs_a),
        .video_en(en_a), .video_hcnt(hc_a), .video_vcnt(vc_a), .htotal(ht_a),
        .vtotal(vt_a), .locked(lk_a), .frame_start(fs_a)
    );

    tmds_timing_gen #(
        .HCNT_W(HW), .VCNT_W(VW), .HS_POL(1'b0), .VS_POL(1'b0),
        .H_START(20), .H_ACTIVE(64), .V_START(3), .V_ACTIVE(15), .LOCK_FRAMES(2)
    ) dut_b (
        .rx0_pclk(clk), .rstbtn_n(rst), .rx0_hsync(hs_b), .rx0_vsync(vs_b),
        .video_en(en_b), .video_hcnt(hc_b), .video_vcnt(vc_b), .htotal(ht_b),
        .vtotal(vt_b), .locked(lk_b), .frame_start(fs_b)
    );

    // Per-frame video_en count and counters of the first enabled pixel.
    int            en_cnt_a = 0, en_last_a = 0, first_h_a = -1, first_v_a = -1;
    int            en_cnt_b = 0, en_last_b = 0, first_h_b = -1, first_v_b = -1;
    logic          got_a = 1'b0, got_b = 1'b0;
    logic [HW-1:0] hprev_a = '0, hprev_b = '0;
    logic [VW-1:0] vprev_a = '0, vprev_b = '0;

    always @(negedge clk) begin
        hprev_a <= hc_a;
        vprev_a <= vc_a;
        if (fs_a) begin
            en_last_a <= en_cnt_a;
            en_cnt_a  <= 0;
            got_a     <= 1'b0;
        end else begin
            en_cnt_a <= en_cnt_a + int'(en_a);
            if (en_a && !got_a) begin
                first_h_a <= int'(hprev_a);
                first_v_a <= int'(vprev_a);
                got_a     <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        hprev_b <= hc_b;
        vprev_b <= vc_b;
        if (fs_b) begin
            en_last_b <= en_cnt_b;
            en_cnt_b  <= 0;
            got_b     <= 1'b0;
        end else begin
            en_cnt_b <= en_cnt_b + int'(en_b);
            if (en_b && !got_b) begin
                first_h_b <= int'(hprev_b);
                first_v_b <= int'(vprev_b);
                got_b     <= 1'b1;
            end
        end
    end

    // One pixel clock of stimulus; instance b always sees the inverted levels.
    task automatic step(input logic h, input logic v);
        hs_a = h;
        vs_a = v;
        hs_b = ~h;
        vs_b = ~v;
        @(posedge clk);
        #1;
    endtask

    // hsync is active for clocks 0..9 of a line; vsync for 200 clocks from voff.
    task automatic run_line(input int line, input int len, input int start, input int voff);
        for (int c = start; c < len; c++) begin
            step(c < 10, (line * 100 + c >= voff) && (line * 100 + c < voff + 200));
        end
    endtask

    task automatic run_frame(input int voff);
        for (int l = 0; l < 20; l++) begin
            run_line(l, 100, 0, voff);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL rst_video_en: actual %0b required 0", en_a); end
        n_checks++; if (hc_a !== '0) begin n_fail++; $display("FAIL rst_hcnt: actual %0d required 0", hc_a); end
        n_checks++; if (vc_a !== '0) begin n_fail++; $display("FAIL rst_vcnt: actual %0d required 0", vc_a); end
        n_checks++; if (ht_a !== '0) begin n_fail++; $display("FAIL rst_htotal: actual %0d required 0", ht_a); end
        n_checks++; if (vt_a !== '0) begin n_fail++; $display("FAIL rst_vtotal: actual %0d required 0", vt_a); end
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL rst_locked: actual %0b required 0", lk_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: actual %0b required 0", fs_a); end
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        run_frame(50);
        run_frame(50);
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL nom_locked_after_2vs: actual %0b required 0", lk_a); end
        n_checks++; if (lk_b !== 1'b0) begin n_fail++; $display("FAIL pol_locked_after_2vs: actual %0b required 0", lk_b); end
        run_frame(50);
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL nom_locked_after_3vs: actual %0b required 1", lk_a); end
        n_checks++; if (lk_b !== 1'b1) begin n_fail++; $display("FAIL pol_locked_after_3vs: actual %0b required 1", lk_b); end
        n_checks++; if (ht_a !== 12'd100) begin n_fail++; $display("FAIL nom_htotal: actual %0d required 100", ht_a); end
        n_checks++; if (vt_a !== 11'd20) begin n_fail++; $display("FAIL nom_vtotal: actual %0d required 20", vt_a); end
        run_frame(50);
        n_checks++; if (en_last_a != 960) begin n_fail++; $display("FAIL nom_en_count: actual %0d required 960", en_last_a); end
        n_checks++; if (first_h_a != 20) begin n_fail++; $display("FAIL nom_first_hcnt: actual %0d required 20", first_h_a); end
        n_checks++; if (first_v_a != 3) begin n_fail++; $display("FAIL nom_first_vcnt: actual %0d required 3", first_v_a); end
    endtask

    task automatic test_polarity;
        run_frame(50);
        n_checks++; if (ht_b !== 12'd100) begin n_fail++; $display("FAIL pol_htotal: actual %0d required 100", ht_b); end
        n_checks++; if (vt_b !== 11'd20) begin n_fail++; $display("FAIL pol_vtotal: actual %0d required 20", vt_b); end
        n_checks++; if (lk_b !== 1'b1) begin n_fail++; $display("FAIL pol_locked: actual %0b required 1", lk_b); end
        n_checks++; if (hc_b !== 12'd98) begin n_fail++; $display("FAIL pol_hcnt_eol: actual %0d required 98", hc_b); end
        n_checks++; if (vc_b !== 11'd19) begin n_fail++; $display("FAIL pol_vcnt_eof: actual %0d required 19", vc_b); end
        n_checks++; if (en_last_b != 960) begin n_fail++; $display("FAIL pol_en_count: actual %0d required 960", en_last_b); end
        n_checks++; if (first_h_b != 20) begin n_fail++; $display("FAIL pol_first_hcnt: actual %0d required 20", first_h_b); end
        n_checks++; if (first_v_b != 3) begin n_fail++; $display("FAIL pol_first_vcnt: actual %0d required 3", first_v_b); end
    endtask

    task automatic test_line_glitch;
        for (int l = 0; l < 10; l++) run_line(l, 100, 0, 50);
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL glitch_pre_locked: actual %0b required 1", lk_a); end
        run_line(10, 98, 0, 50);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++; if (ht_a !== 12'd98) begin n_fail++; $display("FAIL glitch_htotal: actual %0d required 98", ht_a); end
        n_checks++; if (hc_a !== 12'd0) begin n_fail++; $display("FAIL glitch_hcnt: actual %0d required 0", hc_a); end
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL glitch_locked: actual %0b required 0", lk_a); end
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL glitch_video_en: actual %0b required 0", en_a); end
        run_line(11, 100, 2, 50);
        for (int l = 12; l < 20; l++) run_line(l, 100, 0, 50);
        run_frame(50);
        run_frame(50);
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL glitch_relock_early: actual %0b required 0", lk_a); end
        run_frame(50);
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL glitch_relock: actual %0b required 1", lk_a); end
    endtask

    task automatic test_reset_mid;
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_locked: actual %0b required 1", lk_a); end
        fork
            run_frame(50);
            begin
                repeat (550) @(posedge clk);
                #3 rst = 1'b1;
                #1;
                n_checks++; if (hc_a !== '0) begin n_fail++; $display("FAIL rmid_hcnt: actual %0d required 0", hc_a); end
                n_checks++; if (vc_a !== '0) begin n_fail++; $display("FAIL rmid_vcnt: actual %0d required 0", vc_a); end
                n_checks++; if (ht_a !== '0) begin n_fail++; $display("FAIL rmid_htotal: actual %0d required 0", ht_a); end
                n_checks++; if (vt_a !== '0) begin n_fail++; $display("FAIL rmid_vtotal: actual %0d required 0", vt_a); end
                n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL rmid_locked: actual %0b required 0", lk_a); end
                n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL rmid_video_en: actual %0b required 0", en_a); end
                n_checks++; if (lk_b !== 1'b0) begin n_fail++; $display("FAIL rmid_locked_b: actual %0b required 0", lk_b); end
                repeat (3) @(posedge clk);
                #3;
                n_checks++; if (hc_a !== '0) begin n_fail++; $display("FAIL rmid_hcnt_held: actual %0d required 0", hc_a); end
                rst = 1'b0;
            end
        join
        run_frame(50);
        run_frame(50);
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL rmid_locked_2vs: actual %0b required 0", lk_a); end
        run_frame(50);
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL rmid_locked_3vs: actual %0b required 1", lk_a); end
        n_checks++; if (vt_a !== 11'd20) begin n_fail++; $display("FAIL rmid_vtotal_relock: actual %0d required 20", vt_a); end
    endtask

    task automatic test_simultaneous;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_checks++; if (hc_a !== 12'd0) begin n_fail++; $display("FAIL sim_hcnt: actual %0d required 0", hc_a); end
        n_checks++; if (vc_a !== 11'd0) begin n_fail++; $display("FAIL sim_vcnt: actual %0d required 0", vc_a); end
        n_checks++; if (fs_a !== 1'b1) begin n_fail++; $display("FAIL sim_frame_start: actual %0b required 1", fs_a); end
        n_checks++; if (vt_a !== 11'd19) begin n_fail++; $display("FAIL sim_vtotal: actual %0d required 19", vt_a); end
        n_checks++; if (ht_a !== 12'd100) begin n_fail++; $display("FAIL sim_htotal: actual %0d required 100", ht_a); end
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL sim_vtotal_change_unlock: actual %0b required 0", lk_a); end
        step(1'b1, 1'b1);
        n_checks++; if (fs_a !== 1'b0) begin n_fail++; $display("FAIL sim_frame_start_once: actual %0b required 0", fs_a); end
        run_line(0, 100, 3, 0);
        for (int l = 1; l < 20; l++) run_line(l, 100, 0, 0);
        n_checks++; if (vc_a !== 11'd19) begin n_fail++; $display("FAIL sim_vcnt_eof: actual %0d required 19", vc_a); end
    endtask

    task automatic test_sync_loss;
        run_frame(50);
        run_frame(50);
        run_frame(50);
        n_checks++; if (lk_a !== 1'b1) begin n_fail++; $display("FAIL loss_pre_locked: actual %0b required 1", lk_a); end
        repeat (4200) step(1'b0, 1'b0);
        n_checks++; if (hc_a !== 12'd4095) begin n_fail++; $display("FAIL loss_hcnt_sat: actual %0d required 4095", hc_a); end
        n_checks++; if (lk_a !== 1'b0) begin n_fail++; $display("FAIL loss_locked: actual %0b required 0", lk_a); end
        n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL loss_video_en: actual %0b required 0", en_a); end
        repeat (20) step(1'b0, 1'b0);
        n_checks++; if (hc_a !== 12'd4095) begin n_fail++; $display("FAIL loss_no_wrap: actual %0d required 4095", hc_a); end
        n_checks++; if (hc_b !== 12'd4095) begin n_fail++; $display("FAIL loss_hcnt_sat_b: actual %0d required 4095", hc_b); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_polarity();
        test_line_glitch();
        test_reset_mid();
        test_simultaneous();
        test_sync_loss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
